// File: rtl/parking_gate_ctrl.sv
// Parking lot occupancy tracker and entry/exit barrier sequencer.
// Optional rejected-entry counter is built when PARKING_REJECT_CNT_EN is defined.
module parking_gate_ctrl #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int GATE_CYCLES = 80000000,
    parameter int GATE_W      = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_pulse,
    input  logic             exit_pulse,
    output logic             gate_in_open,
    output logic             gate_out_open,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] free_spaces,
    output logic             full,
    output logic             empty,
    output logic             entry_reject,
    output logic [7:0]       rej_count
);

    localparam logic [CNT_W-1:0]  CAP    = CNT_W'(CAPACITY);
    localparam logic [GATE_W-1:0] T_LOAD = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, IN_OPEN, OUT_OPEN} state_t;

    state_t            state;
    logic              pend_in;
    logic              pend_out;
    logic [GATE_W-1:0] timer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pend_in       <= 1'b0;
            pend_out      <= 1'b0;
            occupancy     <= '0;
            timer         <= '0;
            gate_in_open  <= 1'b0;
            gate_out_open <= 1'b0;
            entry_reject  <= 1'b0;
        end else begin
            entry_reject <= 1'b0;
            case (state)
                IDLE: begin
                    // Exit first: freeing a space lets a waiting entry succeed.
                    if (exit_pulse || pend_out) begin
                        pend_out <= 1'b0;
                        pend_in  <= pend_in | entry_pulse;
                        if (occupancy != '0) begin
                            state         <= OUT_OPEN;
                            occupancy     <= occupancy - 1'b1;
                            timer         <= T_LOAD;
                            gate_out_open <= 1'b1;
                        end
                    end else if (entry_pulse || pend_in) begin
                        pend_in <= 1'b0;
                        if (occupancy < CAP) begin
                            state        <= IN_OPEN;
                            occupancy    <= occupancy + 1'b1;
                            timer        <= T_LOAD;
                            gate_in_open <= 1'b1;
                        end else begin
                            entry_reject <= 1'b1;
                        end
                    end
                end
                IN_OPEN, OUT_OPEN: begin
                    pend_in  <= pend_in | entry_pulse;
                    pend_out <= pend_out | exit_pulse;
                    if (timer == '0) begin
                        state         <= IDLE;
                        gate_in_open  <= 1'b0;
                        gate_out_open <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    gate_in_open  <= 1'b0;
                    gate_out_open <= 1'b0;
                end
            endcase
        end
    end

    assign free_spaces = CAP - occupancy;
    assign full        = (occupancy == CAP);
    assign empty       = (occupancy == '0);

`ifdef PARKING_REJECT_CNT_EN
    logic [7:0] rej_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rej_cnt_q <= '0;
        else if (entry_reject && rej_cnt_q != 8'hFF)
            rej_cnt_q <= rej_cnt_q + 8'd1;
    end

    assign rej_count = rej_cnt_q;
`else
    assign rej_count = 8'd0;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with CAPACITY=2, GATE_CYCLES=4.
module tb_parking_gate_ctrl;

    localparam int CAP = 2;
    localparam int CW  = 4;
    localparam int GC  = 4;
    localparam int GW  = 3;
`ifdef PARKING_REJECT_CNT_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    typedef struct {
        logic en;
        logic ex;
        logic gi;
        logic go;
        logic rej;
        int   occ;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          entry_pulse = 1'b0;
    logic          exit_pulse = 1'b0;
    logic          gate_in_open, gate_out_open, full, empty, entry_reject;
    logic [CW-1:0] occupancy, free_spaces;
    logic [7:0]    rej_count;

    int   n_vec = 0;
    int   n_bad = 0;
    int   rc_model = 0;
    vec_t vecs[$];

    parking_gate_ctrl #(.CAPACITY(CAP), .CNT_W(CW), .GATE_CYCLES(GC), .GATE_W(GW)) dut (
        .clk(clk), .reset(reset), .entry_pulse(entry_pulse), .exit_pulse(exit_pulse),
        .gate_in_open(gate_in_open), .gate_out_open(gate_out_open),
        .occupancy(occupancy), .free_spaces(free_spaces), .full(full), .empty(empty),
        .entry_reject(entry_reject), .rej_count(rej_count)
    );

    always #5 clk = ~clk;

    task automatic add(input logic en, input logic ex, input logic gi, input logic go,
                       input logic rej, input int occ);
        vec_t v;
        v.en = en; v.ex = ex; v.gi = gi; v.go = go; v.rej = rej; v.occ = occ;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic gi, input logic go,
                         input logic rej, input int occ);
        int   exp_rc;
        logic ok;
        exp_rc = RC_EN ? rc_model : 0;
        ok = (gate_in_open === gi) && (gate_out_open === go) && (entry_reject === rej) &&
             (occupancy === CW'(occ)) && (free_spaces === CW'(CAP - occ)) &&
             (full === (occ == CAP)) && (empty === (occ == 0)) && (rej_count === 8'(exp_rc));
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got gi=%b go=%b rej=%b occ=%0d free=%0d full=%b empty=%b rc=%0d; want gi=%b go=%b rej=%b occ=%0d free=%0d full=%b empty=%b rc=%0d",
                     name, gate_in_open, gate_out_open, entry_reject, occupancy, free_spaces,
                     full, empty, rej_count, gi, go, rej, occ, CAP - occ, occ == CAP, occ == 0, exp_rc);
        end
    endtask

    initial begin
        // two entries, then a refused third entry
        add(1, 0, 1, 0, 0, 1); repeat (3) add(0, 0, 1, 0, 0, 1); add(0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 0, 0, 2); repeat (3) add(0, 0, 1, 0, 0, 2); add(0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 1, 2); add(0, 0, 0, 0, 0, 2);
        // simultaneous pulses while full: exit first, latched entry after one idle cycle
        add(1, 1, 0, 1, 0, 1); repeat (3) add(0, 0, 0, 1, 0, 1); add(0, 0, 0, 0, 0, 1);
        repeat (4) add(0, 0, 1, 0, 0, 2); add(0, 0, 0, 0, 0, 2);
        // drain the lot
        add(0, 1, 0, 1, 0, 1); repeat (3) add(0, 0, 0, 1, 0, 1); add(0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0); repeat (3) add(0, 0, 0, 1, 0, 0); add(0, 0, 0, 0, 0, 0);
        // exit on an empty lot is dropped
        add(0, 1, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0);
        // three extra entry pulses during IN_OPEN yield exactly one more opening
        add(1, 0, 1, 0, 0, 1); repeat (3) add(1, 0, 1, 0, 0, 1); add(0, 0, 0, 0, 0, 1);
        repeat (4) add(0, 0, 1, 0, 0, 2); add(0, 0, 0, 0, 0, 2); add(0, 0, 0, 0, 0, 2);

        repeat (2) @(posedge clk);
        #1 check("reset_state", 0, 0, 0, 0);
        reset = 1'b0;

        // reset asserted mid-open drops the gate without waiting for a clock
        entry_pulse = 1'b1;
        @(posedge clk); #1 entry_pulse = 1'b0;
        @(posedge clk); #1 check("pre_reset_open", 1, 0, 0, 1);
        #2 reset = 1'b1;
        #1 check("async_reset_gate", 0, 0, 0, 0);
        @(posedge clk); #1 reset = 1'b0;
        exit_pulse = 1'b1;
        @(posedge clk); #1 exit_pulse = 1'b0;
        check("post_reset_exit", 0, 0, 0, 0);
        repeat (4) begin
            @(posedge clk); #1 check("post_reset_idle", 0, 0, 0, 0);
        end

        foreach (vecs[i]) begin
            entry_pulse = vecs[i].en;
            exit_pulse  = vecs[i].ex;
            @(posedge clk); #1;
            entry_pulse = 1'b0;
            exit_pulse  = 1'b0;
            check($sformatf("vec%0d", i), vecs[i].gi, vecs[i].go, vecs[i].rej, vecs[i].occ);
            if (vecs[i].rej) rc_model++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
